// File: rtl/syscall_seq_pkg.sv
// Shared types and constants for the syscall run-control sequencer.
package syscall_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  localparam logic [31:0] PRINT_CODE_DEF = 32'h0000_0022;
  localparam logic [31:0] EXIT_CODE_DEF  = 32'h0000_000A;

  // Register-file indices steered onto R1/R2 while a syscall is decoded
  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;

endpackage

// File: rtl/syscall_sequencer_if.sv
// Core-side bundle of the syscall sequencer: decoder/regfile inputs, PC/display outputs.
interface syscall_sequencer_if;
  logic        syscall;
  logic [31:0] v0_val;
  logic [31:0] a0_val;
  logic        go;
  logic        pc_en;
  logic        halted;
  logic        paused;
  logic [31:0] disp_val;
  logic        disp_upd;
  logic [31:0] instr_count;
  logic [15:0] sys_count;

  modport slave (
    input  syscall, v0_val, a0_val, go,
    output pc_en, halted, paused, disp_val, disp_upd, instr_count, sys_count
  );

  modport master (
    output syscall, v0_val, a0_val, go,
    input  pc_en, halted, paused, disp_val, disp_upd, instr_count, sys_count
  );
endinterface

// File: rtl/syscall_sequencer_go_conditioner.sv
// Go button conditioning: synchronizer, optional debouncer, rising-edge detect.
// Debouncer present only when SYSCALL_SEQ_DEBOUNCE_EN is defined.
module go_conditioner #(
  parameter int SYNC_STAGES = 2
`ifdef SYSCALL_SEQ_DEBOUNCE_EN
  , parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  output logic go_edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   level_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], go_i};
  end

`ifdef SYSCALL_SEQ_DEBOUNCE_EN
  logic        acc_q;
  logic [19:0] cnt_q;

  // Any cycle agreeing with the accepted level restarts the stability window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] != acc_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        acc_q <= ~acc_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = acc_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d_q <= 1'b0;
    else     level_d_q <= level;
  end

  assign go_edge_o = level & ~level_d_q;

endmodule

// File: rtl/syscall_sequencer.sv
// Run-control FSM for the single-cycle MIPS core: gates PC advance around SYSCALL.
// Optional Go debouncing via SYSCALL_SEQ_DEBOUNCE_EN.
module syscall_sequencer
  import syscall_seq_pkg::*;
#(
  parameter logic [31:0] PRINT_CODE  = PRINT_CODE_DEF,
  parameter logic [31:0] EXIT_CODE   = EXIT_CODE_DEF,
  parameter int          SYNC_STAGES = 2
`ifdef SYSCALL_SEQ_DEBOUNCE_EN
  , parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  syscall_sequencer_if.slave bus
);

  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] PAUSE = ST_PAUSE;
  localparam logic [1:0] STEP  = ST_STEP;
  localparam logic [1:0] HALT  = ST_HALT;

  logic [1:0]  state_q, state_d;
  logic        pc_en, accept, print;
  logic        go_edge;
  logic [31:0] disp_val_q, instr_q;
  logic        disp_upd_q;
  logic [15:0] sys_q;

  go_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES)
`ifdef SYSCALL_SEQ_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
  ) u_go (
    .clk       (clk),
    .rst       (rst),
    .go_i      (bus.go),
    .go_edge_o (go_edge)
  );

  // pc_en is Mealy: the syscall is gated in the same cycle it is decoded
  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    accept  = 1'b0;
    print   = 1'b0;
    case (state_q)
      RUN: begin
        if (!bus.syscall) begin
          pc_en = 1'b1;
        end else begin
          accept = 1'b1;
          if (bus.v0_val == PRINT_CODE) begin
            pc_en = 1'b1;
            print = 1'b1;
          end else if (bus.v0_val == EXIT_CODE) begin
            state_d = HALT;
          end else begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: if (go_edge) state_d = STEP;
      STEP: begin
        pc_en   = 1'b1;
        state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      disp_val_q <= '0;
      disp_upd_q <= 1'b0;
      instr_q    <= '0;
      sys_q      <= '0;
    end else begin
      state_q    <= state_d;
      disp_upd_q <= print;
      instr_q    <= instr_q + {31'd0, pc_en};
      sys_q      <= sys_q + {15'd0, accept};
      if (print) disp_val_q <= bus.a0_val;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.halted      = (state_q == HALT);
  assign bus.paused      = (state_q == PAUSE);
  assign bus.disp_val    = disp_val_q;
  assign bus.disp_upd    = disp_upd_q;
  assign bus.instr_count = instr_q;
  assign bus.sys_count   = sys_q;

endmodule
